// File: rtl/poly_x_sweep_if.sv
// Sweep request, evaluator tap and (x, result, index) valid/ready output of poly_x_sweep.
// The ovf flag only exists when SWEEP_OVF_DETECT_EN is defined.
interface poly_x_sweep_if #(
    parameter int W     = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic [W-1:0]     x_start;
    logic [W-1:0]     x_step;
    logic [CNT_W-1:0] n_points;
    logic [W-1:0]     x_eval;
    logic [W-1:0]     result_in;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_x;
    logic [W-1:0]     out_result;
    logic [CNT_W-1:0] out_index;
    logic             busy;
    logic             done;
`ifdef SWEEP_OVF_DETECT_EN
    logic             ovf;
`endif

    modport master (
        input  start, x_start, x_step, n_points, result_in, out_ready,
        output x_eval, out_valid, out_x, out_result, out_index, busy, done
`ifdef SWEEP_OVF_DETECT_EN
        , output ovf
`endif
    );

    modport slave (
        output start, x_start, x_step, n_points, result_in, out_ready,
        input  x_eval, out_valid, out_x, out_result, out_index, busy, done
`ifdef SWEEP_OVF_DETECT_EN
        , input ovf
`endif
    );
endinterface

// File: rtl/poly_x_sweep.sv
// Steps x over n points into a combinational evaluator; first out_valid 2 cycles after start, then 1 point/cycle.
// A stalled output holds out_* and freezes x/idx. SWEEP_OVF_DETECT_EN ends the sweep early on signed x overflow.
module poly_x_sweep #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    poly_x_sweep_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state, state_nxt;
    logic signed [W-1:0] x_cur, step, x_next;
    logic [CNT_W-1:0]    idx, n;
    logic                out_valid;
    logic [W-1:0]        out_x, out_result;
    logic [CNT_W-1:0]    out_index;
    logic                done, done_nxt;
    logic                cap, acc, last, launch, stop_early;

    assign x_next = x_cur + step;
    assign last   = (idx == n - CNT_W'(1));
    assign acc    = out_valid && bus.out_ready;
    assign launch = (state == IDLE) && bus.start && (bus.n_points != '0);

`ifdef SWEEP_OVF_DETECT_EN
    logic ovf;
    // Same-sign operands giving a different-sign sum means x left the signed range.
    assign stop_early = (x_cur[W-1] == step[W-1]) && (x_next[W-1] != x_cur[W-1]) && !last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (launch)
            ovf <= 1'b0;
        else if (cap && stop_early)
            ovf <= 1'b1;
    end

    assign bus.ovf = ovf;
`else
    assign stop_early = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.n_points != '0)
                        state_nxt = RUN;
                    else
                        done_nxt = 1'b1;
                end
            end
            RUN: begin
                cap = !out_valid || bus.out_ready;
                if (cap && (last || stop_early))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (acc) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cur      <= '0;
            step       <= '0;
            n          <= '0;
            idx        <= '0;
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_result <= '0;
            out_index  <= '0;
            done       <= 1'b0;
        end else begin
            done <= done_nxt;
            if (launch) begin
                x_cur <= bus.x_start;
                step  <= bus.x_step;
                n     <= bus.n_points;
                idx   <= '0;
            end
            if (cap) begin
                out_x      <= x_cur;
                out_result <= bus.result_in;
                out_index  <= idx;
                out_valid  <= 1'b1;
                x_cur      <= x_next;
                idx        <= idx + CNT_W'(1);
            end else if (acc) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.x_eval     = x_cur;
    assign bus.out_valid  = out_valid;
    assign bus.out_x      = out_x;
    assign bus.out_result = out_result;
    assign bus.out_index  = out_index;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done;
endmodule

// File: tb/tb_poly_x_sweep.sv
// Randomized sweeps against a power-sum reference model; a scoreboard queue is filled at start
// and drained by a monitor on every output handshake.
module tb_poly_x_sweep;
    localparam int W     = 32;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    poly_x_sweep_if #(.W(W), .CNT_W(CNT_W)) bus ();
    poly_x_sweep #(.W(W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] x;
        logic [31:0] r;
        logic [15:0] i;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   errors    = 0;
    bit   rdy_rand  = 1'b0;
    int   stall_idx = -1;
    int   stall_cnt = 0;

    // Evaluator stand-in: Horner form, a0..a4 = 2,-3,1,5,-4.
    function automatic int horner(input int x);
        int r;
        r = -4;
        r = r * x + 5;
        r = r * x + 1;
        r = r * x - 3;
        r = r * x + 2;
        return r;
    endfunction

    // Reference: plain sum of a_k * x^k.
    function automatic int poly_ref(input int x);
        int a[5];
        int p;
        int s;
        a = '{2, -3, 1, 5, -4};
        p = 1;
        s = 0;
        for (int k = 0; k < 5; k++) begin
            s = s + a[k] * p;
            p = p * x;
        end
        return s;
    endfunction

    assign bus.result_in = horner(bus.x_eval);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_model(input logic [31:0] xs, input logic [31:0] st, input logic [15:0] np,
                              output int m, output bit ovf_exp);
        longint xv;
        exp_t   e;
        m       = 0;
        ovf_exp = 1'b0;
        xv      = longint'($signed(xs));
        for (int i = 0; i < int'(np); i++) begin
            e.x = xv[31:0];
            e.r = poly_ref(int'(e.x));
            e.i = i[15:0];
            q.push_back(e);
            m++;
            if (i == int'(np) - 1) break;
            xv = xv + longint'($signed(st));
`ifdef SWEEP_OVF_DETECT_EN
            if (xv > 64'sd2147483647 || xv < -64'sd2147483648) begin
                ovf_exp = 1'b1;
                break;
            end
`else
            xv = longint'($signed(xv[31:0]));
`endif
        end
    endtask

    task automatic sweep(input logic [31:0] xs, input logic [31:0] st, input logic [15:0] np, input bit poke);
        int m;
        bit ovf_exp;
        int cyc;
        bit got;
        bit timed;
        timed = !rdy_rand && (stall_idx < 0);
        push_model(xs, st, np, m, ovf_exp);
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.x_start  = xs;
        bus.x_step   = st;
        bus.n_points = np;
        got = 1'b0;
        for (cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (poke && cyc == 3) begin
                bus.start   = 1'b1;
                bus.x_start = 32'd100;
            end
            if (cyc == 1) chk("busy_after_start", bus.busy, np != 0);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout actual=no_done required=done");
        end else begin
            chk("busy_at_done", bus.busy, 0);
            chk("valid_at_done", bus.out_valid, 0);
            if (timed) chk("done_latency", cyc, (m == 0) ? 1 : m + 2);
            chk("points_left", q.size(), 0);
`ifdef SWEEP_OVF_DETECT_EN
            chk("ovf", bus.ovf, ovf_exp);
`endif
            @(posedge clk); #1;
            chk("done_one_cycle", bus.done, 0);
        end
    endtask

    // out_ready driver: forced-low window, random, or held high.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_cnt > 0) begin
                bus.out_ready = 1'b0;
                stall_cnt--;
            end else begin
                bus.out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    initial begin : monitor
        logic        hv;
        logic [31:0] hx, hr;
        logic [15:0] hi;
        exp_t        e;
        hv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hv = 1'b0;
            end else begin
                if (hv) begin
                    chk("stall_valid", bus.out_valid, 1);
                    chk("stall_x", bus.out_x, hx);
                    chk("stall_result", bus.out_result, hr);
                    chk("stall_index", bus.out_index, hi);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_point actual=idx%0d required=none", bus.out_index);
                    end else begin
                        e = q.pop_front();
                        chk("out_x", bus.out_x, e.x);
                        chk("out_result", bus.out_result, e.r);
                        chk("out_index", bus.out_index, e.i);
                        if (stall_idx >= 0 && int'(e.i) == stall_idx) stall_cnt = 3;
                    end
                end
                hv = bus.out_valid && !bus.out_ready;
                hx = bus.out_x;
                hr = bus.out_result;
                hi = bus.out_index;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int  m;
        bit  ovf_exp;
        bit  found;
        logic [31:0] rs;
        bus.start    = 1'b0;
        bus.x_start  = '0;
        bus.x_step   = '0;
        bus.n_points = '0;

        #12;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_out_x", bus.out_x, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_index", bus.out_index, 0);
        chk("rst_x_eval", bus.x_eval, 0);
        rst = 1'b0;

        sweep(-32'sd2, 32'd1, 16'd5, 1'b0);     // full throughput
        stall_idx = 1;
        sweep(-32'sd2, 32'd1, 16'd5, 1'b0);     // 3-cycle stall after idx 1
        stall_idx = -1;
        sweep(32'd7, 32'd3, 16'd0, 1'b0);       // empty sweep
        sweep(-32'sd2, 32'd1, 16'd5, 1'b1);     // start during RUN ignored

        // reset while idx 2 is presented
        push_model(-32'sd2, 32'd1, 16'd5, m, ovf_exp);
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.x_start  = -32'sd2;
        bus.x_step   = 32'd1;
        bus.n_points = 16'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_index == 16'd2) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_idx2", found, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_out_x", bus.out_x, 0);
        chk("abort_out_result", bus.out_result, 0);
        chk("abort_out_index", bus.out_index, 0);
        q.delete();
        @(negedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_no_done", bus.done, 0);
        sweep(-32'sd2, 32'd1, 16'd5, 1'b0);

        sweep(32'h7FFF_FFFE, 32'd1, 16'd4, 1'b0);   // signed overflow boundary
        sweep(32'h8000_0001, -32'sd1, 16'd4, 1'b0);

        for (int t = 0; t < 10; t++) begin
            rdy_rand = t[0];
            if ($urandom_range(0, 1) != 0)
                rs = $urandom;
            else
                rs = $urandom_range(0, 20) - 10;
            sweep($urandom, rs, 16'($urandom_range(1, 12)), 1'b0);
        end
        rdy_rand = 1'b0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
